// File: rtl/suprloco_pkg.sv
// rtl/suprloco_pkg.sv - shared constants and state type for the SuprLoco CPU ROM interface
package suprloco_pkg;

  localparam int          CPU_CLK_DIV     = 12;
  localparam logic [15:0] ROM_TOP_DEFAULT = 16'hC000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } romif_state_t;

endpackage

// File: rtl/suprloco_cen_gen.sv
// rtl/suprloco_cen_gen.sv - Z80 positive/negative phase clock enables from the master clock
module suprloco_cen_gen
  import suprloco_pkg::*;
#(
  parameter int CLK_DIV = CPU_CLK_DIV
) (
  input  logic i_CLK,
  input  logic i_RST,
  output logic o_PCEN,
  output logic o_NCEN
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  // Reset parks the counter on its last value so PCEN fires on the first post-reset edge.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      count <= CW'(CLK_DIV - 1);
    end else if (count == CW'(CLK_DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_PCEN = (count == CW'(0));
  assign o_NCEN = (count == CW'(CLK_DIV / 2));

endmodule

// File: rtl/suprloco_cpu_romif.sv
// rtl/suprloco_cpu_romif.sv - main CPU bus front end: CENs, cached ROM fetch with WAIT, VBLANK interrupt
module suprloco_cpu_romif
  import suprloco_pkg::*;
#(
  parameter int          CLK_DIV = CPU_CLK_DIV,
  parameter logic [15:0] ROM_TOP = ROM_TOP_DEFAULT
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  output logic        o_PCEN,
  output logic        o_NCEN,
  input  logic [15:0] i_CPU_ADDR,
  input  logic        i_CPU_MREQ_n,
  input  logic        i_CPU_RD_n,
  input  logic        i_CPU_RFSH_n,
  input  logic        i_CPU_IORQ_n,
  input  logic        i_CPU_M1_n,
  output logic        o_CPU_WAIT_n,
  output logic [7:0]  o_CPU_DI,
  input  logic [7:0]  i_BUS_DI,
  input  logic        i_VBLANK,
  output logic        o_INT_n,
  output logic        o_ROM_REQ,
  output logic [15:0] o_ROM_ADDR,
  input  logic        i_ROM_ACK,
  input  logic [7:0]  i_ROM_DATA
);

  romif_state_t state, state_nxt;

  logic        cache_valid;
  logic [15:0] cache_tag;
  logic [7:0]  cache_data;
  logic        in_window, rom_access, hit, miss;
  logic        vblank_sync, vblank_dly, vblank_rise, int_ack;

  suprloco_cen_gen #(.CLK_DIV(CLK_DIV)) u_cen_gen (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .o_PCEN (o_PCEN),
    .o_NCEN (o_NCEN)
  );

  assign in_window  = (i_CPU_ADDR < ROM_TOP);
  assign rom_access = ~i_CPU_MREQ_n & ~i_CPU_RD_n & i_CPU_RFSH_n & in_window;
  assign hit        = rom_access & cache_valid & (cache_tag == i_CPU_ADDR);
  assign miss       = rom_access & ~hit;

  // Combinational so the CPU never samples a ready WAIT in the same cycle a miss shows up.
  assign o_CPU_WAIT_n = ~(miss | (state != IDLE));
  assign o_CPU_DI     = in_window ? cache_data : i_BUS_DI;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_ROM_REQ = 1'b0;
    case (state)
      IDLE: if (miss) state_nxt = REQ;
      REQ: begin
        o_ROM_REQ = 1'b1;
        if (i_ROM_ACK) state_nxt = FILL;
      end
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fill is keyed to the latched fetch address, so a CPU that has moved on still gets a coherent entry.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_ROM_ADDR  <= '0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else begin
      if (state == IDLE && miss) o_ROM_ADDR <= i_CPU_ADDR;
      if (state == REQ && i_ROM_ACK) begin
        cache_tag   <= o_ROM_ADDR;
        cache_data  <= i_ROM_DATA;
        cache_valid <= 1'b1;
      end
    end
  end

  assign vblank_rise = vblank_sync & ~vblank_dly;
  assign int_ack     = ~i_CPU_IORQ_n & ~i_CPU_M1_n;

  // A fresh VBLANK edge outranks a simultaneous acknowledge.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      vblank_sync <= 1'b0;
      vblank_dly  <= 1'b0;
      o_INT_n     <= 1'b1;
    end else begin
      vblank_sync <= i_VBLANK;
      vblank_dly  <= vblank_sync;
      if (vblank_rise) begin
        o_INT_n <= 1'b0;
      end else if (int_ack) begin
        o_INT_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_suprloco_cpu_romif.sv
// tb/tb_suprloco_cpu_romif.sv - self-checking bench for suprloco_cpu_romif against a transaction-level model
module tb_suprloco_cpu_romif;

  logic        i_CLK, i_RST;
  logic        o_PCEN, o_NCEN;
  logic [15:0] i_CPU_ADDR;
  logic        i_CPU_MREQ_n, i_CPU_RD_n, i_CPU_RFSH_n, i_CPU_IORQ_n, i_CPU_M1_n;
  logic        o_CPU_WAIT_n;
  logic [7:0]  o_CPU_DI, i_BUS_DI;
  logic        i_VBLANK, o_INT_n;
  logic        o_ROM_REQ;
  logic [15:0] o_ROM_ADDR;
  logic        i_ROM_ACK;
  logic [7:0]  i_ROM_DATA;

  int total = 0;
  int bad   = 0;
  int ack_delay = 1;
  int req_cnt   = 0;

  bit          m_valid = 0;
  logic [15:0] m_tag   = '0;

  suprloco_cpu_romif #(.CLK_DIV(12), .ROM_TOP(16'hC000)) dut (
    .i_CLK        (i_CLK),
    .i_RST        (i_RST),
    .o_PCEN       (o_PCEN),
    .o_NCEN       (o_NCEN),
    .i_CPU_ADDR   (i_CPU_ADDR),
    .i_CPU_MREQ_n (i_CPU_MREQ_n),
    .i_CPU_RD_n   (i_CPU_RD_n),
    .i_CPU_RFSH_n (i_CPU_RFSH_n),
    .i_CPU_IORQ_n (i_CPU_IORQ_n),
    .i_CPU_M1_n   (i_CPU_M1_n),
    .o_CPU_WAIT_n (o_CPU_WAIT_n),
    .o_CPU_DI     (o_CPU_DI),
    .i_BUS_DI     (i_BUS_DI),
    .i_VBLANK     (i_VBLANK),
    .o_INT_n      (o_INT_n),
    .o_ROM_REQ    (o_ROM_REQ),
    .o_ROM_ADDR   (o_ROM_ADDR),
    .i_ROM_ACK    (i_ROM_ACK),
    .i_ROM_DATA   (i_ROM_DATA)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One master clock; the ROM side acks in the ack_delay-th cycle of a request.
  task automatic tick();
    @(posedge i_CLK);
    #1;
    if (i_ROM_ACK) begin
      i_ROM_ACK = 1'b0;
      req_cnt   = 0;
    end else if (o_ROM_REQ) begin
      req_cnt++;
      if (req_cnt >= ack_delay) begin
        i_ROM_ACK  = 1'b1;
        i_ROM_DATA = rom_byte(o_ROM_ADDR);
      end
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] bus, input int delay, input string tag);
    bit in_win, exp_miss, saw_req;
    logic [15:0] req_addr;
    int w;
    ack_delay = delay;
    in_win    = (a < 16'hC000);
    exp_miss  = in_win && !(m_valid && m_tag == a);
    i_CPU_ADDR = a; i_BUS_DI = bus;
    i_CPU_MREQ_n = 1'b0; i_CPU_RD_n = 1'b0; i_CPU_RFSH_n = 1'b1;
    #1;
    w = 0; saw_req = 0; req_addr = '0;
    while (!o_CPU_WAIT_n && w < 50) begin
      w++;
      if (o_ROM_REQ) begin
        saw_req  = 1;
        req_addr = o_ROM_ADDR;
      end
      tick();
      #1;
    end
    chk({tag, "_wait"}, w, exp_miss ? delay + 2 : 0);
    chk({tag, "_req"}, saw_req, exp_miss);
    if (exp_miss) chk({tag, "_addr"}, req_addr, a);
    chk({tag, "_di"}, o_CPU_DI, in_win ? rom_byte(a) : bus);
    tick();
    #1;
    chk({tag, "_noreq"}, {o_ROM_REQ, o_CPU_WAIT_n}, 2'b01);
    i_CPU_MREQ_n = 1'b1; i_CPU_RD_n = 1'b1;
    if (in_win) begin
      m_valid = 1;
      m_tag   = a;
    end
    tick();
  endtask

  initial begin
    i_RST = 1'b1;
    i_CPU_ADDR = '0; i_CPU_MREQ_n = 1'b1; i_CPU_RD_n = 1'b1; i_CPU_RFSH_n = 1'b1;
    i_CPU_IORQ_n = 1'b1; i_CPU_M1_n = 1'b1;
    i_BUS_DI = '0; i_VBLANK = 1'b0; i_ROM_ACK = 1'b0; i_ROM_DATA = '0;
    repeat (3) @(posedge i_CLK);
    #1;
    chk("rst_outs", {o_PCEN, o_NCEN, o_ROM_REQ, o_INT_n, o_CPU_WAIT_n}, 5'b00011);
    chk("rst_addr", o_ROM_ADDR, 16'h0000);
    i_RST = 1'b0;

    for (int i = 0; i < 48; i++) begin
      tick();
      chk($sformatf("pcen_%0d", i), o_PCEN, (i % 12) == 0);
      chk($sformatf("ncen_%0d", i), o_NCEN, (i % 12) == 6);
    end

    cpu_read(16'h1234, 8'h00, 3, "miss1234");
    cpu_read(16'h1234, 8'h00, 3, "hit1234");
    cpu_read(16'hC000, 8'hA5, 1, "outwin");

    i_CPU_ADDR = 16'h0010; i_CPU_MREQ_n = 1'b0; i_CPU_RD_n = 1'b0; i_CPU_RFSH_n = 1'b0;
    #1;
    chk("rfsh_now", {o_ROM_REQ, o_CPU_WAIT_n}, 2'b01);
    tick();
    chk("rfsh_next", {o_ROM_REQ, o_CPU_WAIT_n}, 2'b01);
    i_CPU_MREQ_n = 1'b1; i_CPU_RD_n = 1'b1; i_CPU_RFSH_n = 1'b1;
    tick();

    i_VBLANK = 1'b1;
    tick();
    chk("int_1cyc", o_INT_n, 1'b1);
    tick();
    chk("int_2cyc", o_INT_n, 1'b0);
    i_CPU_IORQ_n = 1'b0; i_CPU_M1_n = 1'b0;
    tick();
    chk("int_ack", o_INT_n, 1'b1);
    i_CPU_IORQ_n = 1'b1; i_CPU_M1_n = 1'b1;
    i_VBLANK = 1'b0;
    repeat (3) tick();
    i_VBLANK = 1'b1;
    tick(); tick();
    chk("int_pend", o_INT_n, 1'b0);
    i_VBLANK = 1'b0;
    repeat (3) tick();
    i_VBLANK = 1'b1;
    tick();
    i_CPU_IORQ_n = 1'b0; i_CPU_M1_n = 1'b0;
    tick();
    chk("int_edge_wins", o_INT_n, 1'b0);
    tick();
    chk("int_ack2", o_INT_n, 1'b1);
    i_CPU_IORQ_n = 1'b1; i_CPU_M1_n = 1'b1;
    tick();

    ack_delay = 1000;
    i_CPU_ADDR = 16'h0200; i_CPU_MREQ_n = 1'b0; i_CPU_RD_n = 1'b0;
    tick();
    chk("rreq_up", o_ROM_REQ, 1'b1);
    i_RST = 1'b1;
    #1;
    chk("rreq_async", o_ROM_REQ, 1'b0);
    i_CPU_MREQ_n = 1'b1; i_CPU_RD_n = 1'b1;
    tick();
    i_RST = 1'b0;
    m_valid = 0;
    req_cnt = 0;
    tick();
    i_ROM_ACK = 1'b1; i_ROM_DATA = 8'h99;
    tick();
    chk("late_ack", {o_ROM_REQ, o_CPU_WAIT_n}, 2'b01);
    cpu_read(16'h0200, 8'h00, 2, "reread");

    cpu_read(16'h0000, 8'h00, 1, "cons0");
    cpu_read(16'h0001, 8'h00, 1, "cons1");

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      else a = 16'h0100 + 16'($urandom_range(0, 1));
      cpu_read(a, 8'($urandom), $urandom_range(1, 4), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
